// File: rtl/countdown_ctrl_if.sv
// countdown_ctrl_if: preset-load, run-control and digit/status bundle
// master drives pls/psDS/psUS/start/tick, slave returns ds/us/busy/done.
interface countdown_ctrl_if;
    logic       pls;
    logic [1:0] psDS;
    logic [1:0] psUS;
    logic       start;
    logic       tick;
    logic [1:0] ds;
    logic [3:0] us;
    logic       busy;
    logic       done;

    modport master (
        output pls, psDS, psUS, start, tick,
        input  ds, us, busy, done
    );

    modport slave (
        input  pls, psDS, psUS, start, tick,
        output ds, us, busy, done
    );
endinterface

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: two-digit (tens/units) countdown with load, pause/resume
// and a one-cycle done pulse on expiry.
// Ports: clk, rst (sync, active-high), io (countdown_ctrl_if.slave):
//   pls/psDS/psUS load presets, start runs/pauses, tick decrements,
//   ds/us current digits, busy = RUN, done = registered expiry pulse.
// Option: COUNTDOWN_AUTO_RELOAD_EN reloads the last preset after expiry.
module countdown_ctrl #(
    parameter int unsigned UNITS_MAX = 9
) (
    input logic            clk,
    input logic            rst,
    countdown_ctrl_if.slave io
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADED,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_e;

    localparam logic [3:0] UMAX = 4'(UNITS_MAX);

    state_e     state_q, state_d;
    logic [1:0] ds_q, ds_d;
    logic [3:0] us_q, us_d;
    logic       done_q, done_d;

    logic [1:0] dec_ds;
    logic [3:0] dec_us;
    logic       cnt_zero;
    logic       dec_zero;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [1:0] sh_ds_q, sh_ds_d;
    logic [1:0] sh_us_q, sh_us_d;
    logic       sh_zero;

    assign sh_zero = (sh_ds_q == 2'd0) && (sh_us_q == 2'd0);
`endif

    assign cnt_zero = (ds_q == 2'd0) && (us_q == 4'd0);

    // Next count value for one tick; borrow refills units with UNITS_MAX.
    always_comb begin
        dec_ds = ds_q;
        dec_us = us_q;
        if (us_q != 4'd0) begin
            dec_us = us_q - 4'd1;
        end else if (ds_q != 2'd0) begin
            dec_ds = ds_q - 2'd1;
            dec_us = UMAX;
        end
        dec_zero = (dec_ds == 2'd0) && (dec_us == 4'd0);
    end

    always_comb begin
        state_d = state_q;
        ds_d    = ds_q;
        us_d    = us_q;
        done_d  = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        sh_ds_d = sh_ds_q;
        sh_us_d = sh_us_q;
`endif
        if (io.pls) begin
            // Load beats any tick/start in the same cycle.
            ds_d    = io.psDS;
            us_d    = {2'b00, io.psUS};
            state_d = S_LOADED;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            sh_ds_d = io.psDS;
            sh_us_d = io.psUS;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_LOADED: begin
                    if (io.start) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!io.start) begin
                        state_d = S_PAUSE;
                    end else if (cnt_zero) begin
                        // Entered RUN already at 00: expire without a tick.
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (io.tick) begin
                        ds_d = dec_ds;
                        us_d = dec_us;
                        if (dec_zero) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                S_PAUSE: begin
                    if (io.start) begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    // done_q marks the cycle right after expiry.
                    if (done_q && !sh_zero) begin
                        ds_d    = sh_ds_q;
                        us_d    = {2'b00, sh_us_q};
                        state_d = io.start ? S_RUN : S_PAUSE;
                    end
`else
                    state_d = S_DONE;
`endif
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ds_q    <= 2'd0;
            us_q    <= 4'd0;
            done_q  <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            sh_ds_q <= 2'd0;
            sh_us_q <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            ds_q    <= ds_d;
            us_q    <= us_d;
            done_q  <= done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            sh_ds_q <= sh_ds_d;
            sh_us_q <= sh_us_d;
`endif
        end
    end

    assign io.ds   = ds_q;
    assign io.us   = us_q;
    assign io.busy = (state_q == S_RUN);
    assign io.done = done_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural countdown model.
module tb_countdown_ctrl;

    localparam int U = 9;

    logic clk = 1'b0;
    logic rst;

    countdown_ctrl_if bus ();

    countdown_ctrl #(
        .UNITS_MAX(U)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: mode of operation plus the digit pair.
    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;
    localparam int M_PAUS = 3;
    localparam int M_EXP  = 4;

    int   mode   = M_IDLE;
    int   m_ds   = 0;
    int   m_us   = 0;
    int   sh_ds  = 0;
    int   sh_us  = 0;
    logic m_done = 1'b0;
    bit   mvalid = 1'b0;

    always @(posedge clk) begin
        logic fire;
        fire   = 1'b0;
        mvalid = 1'b1;
        if (rst) begin
            mode  = M_IDLE;
            m_ds  = 0;
            m_us  = 0;
            sh_ds = 0;
            sh_us = 0;
        end else if (bus.pls) begin
            m_ds  = int'(bus.psDS);
            m_us  = int'(bus.psUS);
            sh_ds = m_ds;
            sh_us = m_us;
            mode  = M_LOAD;
        end else begin
            if (mode == M_LOAD) begin
                if (bus.start) mode = M_RUN;
            end else if (mode == M_RUN) begin
                if (!bus.start) begin
                    mode = M_PAUS;
                end else if (m_ds == 0 && m_us == 0) begin
                    mode = M_EXP;
                    fire = 1'b1;
                end else if (bus.tick) begin
                    if (m_us > 0) begin
                        m_us = m_us - 1;
                    end else begin
                        m_ds = m_ds - 1;
                        m_us = U;
                    end
                    if (m_ds == 0 && m_us == 0) begin
                        mode = M_EXP;
                        fire = 1'b1;
                    end
                end
            end else if (mode == M_PAUS) begin
                if (bus.start) mode = M_RUN;
            end else if (mode == M_EXP) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                if (m_done && (sh_ds != 0 || sh_us != 0)) begin
                    m_ds = sh_ds;
                    m_us = sh_us;
                    mode = bus.start ? M_RUN : M_PAUS;
                end
`endif
            end
        end
        m_done = fire;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("cycle",
                {bus.ds, bus.us, bus.busy, bus.done},
                {m_ds[1:0], m_us[3:0], (mode == M_RUN), m_done});
        end
    end

    task automatic step(input logic r, input logic p,
                        input logic [1:0] d, input logic [1:0] u,
                        input logic s, input logic t);
        rst       = r;
        bus.pls   = p;
        bus.psDS  = d;
        bus.psUS  = u;
        bus.start = s;
        bus.tick  = t;
        @(posedge clk);
        #1;
    endtask

    function automatic int cnt();
        return int'(bus.ds) * 10 + int'(bus.us);
    endfunction

    initial begin
        rst       = 1'b1;
        bus.pls   = 1'b0;
        bus.psDS  = 2'd0;
        bus.psUS  = 2'd0;
        bus.start = 1'b0;
        bus.tick  = 1'b0;

        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 1, 1);
            chk("idle", {bus.ds, bus.us, bus.busy, bus.done}, 0);
        end

        step(0, 1, 2'd1, 2'd2, 0, 0);
        chk("load12", cnt(), 12);
        chk("load12_busy", bus.busy, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("run_busy", bus.busy, 1);
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 0, 1, 1);
            chk("cnt12", cnt(), 11 - i);
            chk("model12", m_ds * 10 + m_us, 11 - i);
        end
        chk("exp_done", bus.done, 1);
        chk("exp_busy", bus.busy, 0);
`ifndef COUNTDOWN_AUTO_RELOAD_EN
        step(0, 0, 0, 0, 1, 1);
        chk("done_once", bus.done, 0);
        chk("hold00", cnt(), 0);
`endif

        step(0, 1, 2'd0, 2'd3, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1);
        chk("p_dec", cnt(), 2);
        step(0, 0, 0, 0, 0, 1);
        chk("p_enter", cnt(), 2);
        chk("p_busy", bus.busy, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 1);
            chk("p_hold", cnt(), 2);
        end
        step(0, 0, 0, 0, 1, 1);
        chk("p_resume", cnt(), 2);
        chk("p_rbusy", bus.busy, 1);
        step(0, 0, 0, 0, 1, 1);
        chk("p_01", cnt(), 1);
        step(0, 0, 0, 0, 1, 1);
        chk("p_00", cnt(), 0);
        chk("p_done", bus.done, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("p_done1", bus.done, 0);

        step(0, 1, 2'd1, 2'd0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 1);
        chk("at05", cnt(), 5);
        step(0, 1, 2'd2, 2'd1, 1, 1);
        chk("ld21", cnt(), 21);
        chk("ld21_busy", bus.busy, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("ld21_run", bus.busy, 1);

        step(0, 1, 2'd0, 2'd0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("z_run", bus.busy, 1);
        step(0, 0, 0, 0, 1, 0);
        chk("z_done", bus.done, 1);
        chk("z_busy", bus.busy, 0);
        step(1, 0, 0, 0, 1, 0);
        chk("z_rst", {bus.ds, bus.us, bus.busy, bus.done}, 0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        step(0, 1, 2'd0, 2'd2, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 2; k++) begin
            step(0, 0, 0, 0, 1, 1);
            step(0, 0, 0, 0, 1, 1);
            chk("ar_done", bus.done, 1);
            step(0, 0, 0, 0, 1, 0);
            chk("ar_cnt", cnt(), 2);
            chk("ar_busy", bus.busy, 1);
        end
`endif

        for (int i = 0; i < 3000; i++) begin
            logic r, p, s, t;
            r = ($urandom_range(0, 99) == 0);
            p = ($urandom_range(0, 19) == 0);
            s = ($urandom_range(0, 9) < 8);
            t = ($urandom_range(0, 1) == 1);
            step(r, p, 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), s, t);
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Two-digit countdown counter that consumes the preset digits produced by the timer-preset decoder. On a load strobe it captures the tens/units presets, then counts down one unit per `tick` while running, supporting pause/resume. It signals expiry with a one-cycle `done` pulse and drives the digit values toward the display path.

## Interface
Parameters:
- `UNITS_MAX`, default 9: value loaded into the units digit on a borrow; legal range 1..9.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `pls`  in  1  preset load strobe, sampled every cycle.
- `psDS`  in  2  tens-digit preset value.
- `psUS`  in  2  units-digit preset value, zero-extended to 4 bits on load.
- `start`  in  1  level: 1 = run, 0 = pause.
- `tick`  in  1  single-cycle count enable, e.g. 1 Hz strobe.
- `ds`  out  2  current tens digit.
- `us`  out  4  current units digit, BCD 0..`UNITS_MAX`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle expiry pulse.

## Operation
- States: IDLE, LOADED, RUN, PAUSE, DONE. Reset enters IDLE with `ds`=0, `us`=0, `busy`=0, `done`=0.
- Priority on every edge: `rst` > `pls` > `start`/`tick`.
- `pls`=1 in any state:
  - `ds`←`psDS`, `us`←{2'b00,`psUS`}, next state LOADED.
  - Clears any pending `done`.
  - Any `tick` in the same cycle is ignored.
- LOADED: `start`=1 → RUN. `start`=0 → stay.
- RUN:
  - `start`=0 → PAUSE, ignoring `tick` in that cycle.
  - `tick`=1 with `start`=1 decrements the count:
    - `us`≠0 → `us`−1.
    - `us`=0 and `ds`≠0 → `ds`−1, `us`←`UNITS_MAX`.
  - If the decrement produces 00 → DONE.
  - If RUN is entered with a count of 00 → DONE on the next edge, without needing a `tick`.
- PAUSE: count frozen; `tick` ignored. `start`=1 → RUN.
- DONE: count holds at 00. `start` and `tick` are ignored. Only `pls` or `rst` leave DONE.
- `busy` = (state == RUN).
- `done` is registered:
  - It is high for exactly the one cycle after the edge that enters DONE.
  - It is never asserted twice for a single expiry.
- Count never wraps below 00.

## Timing
- Load latency: `pls` sampled at edge n → preset visible on `ds`/`us` from edge n onward (registered outputs, valid during cycle n+1).
- Decrement latency: `tick` at edge n → new value valid after edge n.
- Expiry: the edge that makes the count 00 also enters DONE. `done`=1 during the following cycle only. `busy` falls on that same edge.
- Zero-preset expiry: `pls` with presets 00 at edge n, `start`=1 at edge n+1 → RUN. At edge n+2 → DONE. `done` is high during the cycle after edge n+2.
- `rst` during any state, including mid-count or on the `done` cycle:
  - Next edge: IDLE, all outputs 0.
  - Any `done` pulse is cut off.
- `pls` and `tick` on the same edge: load wins, no decrement.

## Configuration
- `COUNTDOWN_AUTO_RELOAD_EN` defined:
  - Shadow registers capture the preset on every `pls`.
  - On expiry the `done` pulse fires as normal. On the following edge, the count reloads from the shadow registers and the state returns to RUN, independent of `tick`.
  - If the shadow preset is 00, the block stays in DONE.
  - `start`=0 during the reload edge sends the state to PAUSE instead of RUN.
- Not defined:
  - No shadow registers.
  - DONE holds until `pls` or `rst`, as described in Operation.

## Test plan
- Reset, then idle 5 cycles → `ds`=0, `us`=0, `busy`=0, `done`=0 throughout.
- `psDS`=1, `psUS`=2, `pls`; `start`=1; 12 ticks → count sequence 12,11,10,09,…,01,00. `done` high exactly 1 cycle after the 12th tick; final state DONE, `busy`=0.
- Preset 03, run, 1 tick, `start`=0, then 4 ticks, then `start`=1 and 2 ticks → count holds at 02 while paused, then 01, 00, and `done` fires once.
- `pls` with 21 asserted on the same edge as a `tick` while running at 05 → count becomes 21 with no decrement; state LOADED.
- Preset 00, `start`=1 → DONE on the second edge after `pls`, `done` pulse 1 cycle. `rst` asserted on the `done` cycle → outputs 0 next edge.
- With `COUNTDOWN_AUTO_RELOAD_EN`: preset 02, run, 2 ticks → `done` pulse, then count=02 one edge later, `busy`=1. Repeat 2 ticks → second `done` pulse.
